fixed_point_addsub_arbiter: RTL

Shares a single N-bit fixed-point add/subtract datapath among R requesters. Each requester submits an operation over a valid/ready handshake. A round-robin arbiter grants one request per cycle into a two-stage pipeline: operand register, then result register. Results return on one shared valid/ready response port, tagged with the requester index. The block sits between the datapath clients (accumulators, address generators) and the team's existing FixedPointAdd instance.

---
 rtl/fixed_point_pkg.sv | 18 +
 rtl/FixedPointAdd.sv | 15 +
 rtl/fixed_point_rr_arbiter.sv | 44 ++++
 rtl/fixed_point_addsub_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared types for the fixed-point add/subtract arbiter block.
//   fp_op_e    : requested operation (add, or subtract via inverted b).
//   fp_ctrl_t  : width-independent control part of the stage-1 payload.
// Width-dependent fields (operands, requester id) are declared in the
// block that owns the N/R parameters.
package fixed_point_pkg;

  typedef enum logic {
    FP_OP_ADD = 1'b0,
    FP_OP_SUB = 1'b1
  } fp_op_e;

  typedef struct packed {
    fp_op_e op;
    logic   carry_in;
  } fp_ctrl_t;

endpackage

// File: rtl/FixedPointAdd.sv
// N-bit unsigned adder with carry in/out, modulo 2^N.
// Ports: a, b (operands), carry_in, sum (N bits), carry_out (bit N).
module FixedPointAdd #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carry_in};

endmodule

// File: rtl/fixed_point_rr_arbiter.sv
// R-way round-robin arbiter with a combinational grant.
// Ports: clk, rst (sync, active-high), req_valid (R), accept (strobe: the
// current grant was taken), grant (one-hot or zero), grant_id, grant_any.
// `last` holds the most recently accepted index; the search starts one
// past it, so a granted-but-not-accepted requester keeps its place.
module fixed_point_rr_arbiter #(
  parameter  int R    = 4,
  localparam int ID_W = (R > 1) ? $clog2(R) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    req_valid,
  input  logic            accept,
  output logic [R-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_any
);

  logic [ID_W-1:0] last;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= R; k++) begin
      automatic int idx = (int'(last) + k) % R;
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

  // Reset to R-1 so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= ID_W'(R - 1);
    end else if (accept) begin
      last <= grant_id;
    end
  end

endmodule

// File: rtl/fixed_point_addsub_arbiter.sv
// Shares one FixedPointAdd datapath among R requesters.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_op              : 0 = add, 1 = subtract (a + ~b + carry_in)
//   req_a, req_b        : operands, requester i at [i*N +: N]
//   req_carry_in        : per-requester carry/borrow in
//   rsp_valid/rsp_ready : shared response handshake
//   rsp_id, rsp_c       : originating requester and result
//   rsp_carry_out       : bit N of the sum (for subtract: 1 = no borrow)
// Two stages: operand register (p1) then result register (p2).
module fixed_point_addsub_arbiter
  import fixed_point_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int R    = 4,
  localparam int ID_W = (R > 1) ? $clog2(R) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    req_valid,
  output logic [R-1:0]    req_ready,
  input  logic [R-1:0]    req_op,
  input  logic [R*N-1:0]  req_a,
  input  logic [R*N-1:0]  req_b,
  input  logic [R-1:0]    req_carry_in,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [N-1:0]    rsp_c,
  output logic            rsp_carry_out
);

  typedef struct packed {
    fp_ctrl_t        ctrl;
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic [ID_W-1:0] id;
  } s1_payload_t;

  function automatic logic [N-1:0] adder_b(fp_op_e op, logic [N-1:0] b);
    return (op == FP_OP_SUB) ? ~b : b;
  endfunction

  logic [R-1:0]    grant;
  logic [ID_W-1:0] grant_id;
  logic            grant_any;
  logic            accept;
  logic            s1_free;
  logic            s2_adv;
  s1_payload_t     req_sel_p0;
  s1_payload_t     payload_p1;
  logic            vld_p1;
  logic            vld_p2;
  logic [N-1:0]    sum_p1;
  logic            cout_p1;

  // ---- p0: arbitration and request select ----
  assign s2_adv    = !vld_p2 || rsp_ready;
  assign s1_free   = !vld_p1 || s2_adv;
  assign req_ready = rst ? '0 : (grant & {R{s1_free}});
  assign accept    = grant_any && s1_free && !rst;

  fixed_point_rr_arbiter #(.R(R)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    req_sel_p0               = '0;
    req_sel_p0.ctrl.op       = fp_op_e'(req_op[grant_id]);
    req_sel_p0.ctrl.carry_in = req_carry_in[grant_id];
    req_sel_p0.a             = req_a[int'(grant_id)*N +: N];
    req_sel_p0.b             = req_b[int'(grant_id)*N +: N];
    req_sel_p0.id            = grant_id;
  end

  // ---- p1: operand register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (s1_free) begin
      vld_p1 <= accept;
    end
    if (accept) begin
      payload_p1 <= req_sel_p0;
    end
  end

  FixedPointAdd #(.N(N)) u_add (
    .a         (payload_p1.a),
    .b         (adder_b(payload_p1.ctrl.op, payload_p1.b)),
    .carry_in  (payload_p1.ctrl.carry_in),
    .sum       (sum_p1),
    .carry_out (cout_p1)
  );

  // ---- p2: result register, holds while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2        <= 1'b0;
      rsp_c         <= '0;
      rsp_carry_out <= 1'b0;
      rsp_id        <= '0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        rsp_c         <= sum_p1;
        rsp_carry_out <= cout_p1;
        rsp_id        <= payload_p1.id;
      end
    end
  end

  assign rsp_valid = vld_p2;

endmodule
